// File: rtl/link_power_sequencer.sv
// ============================================================================
// Module   : link_power_sequencer
// Purpose  : Shared detect/soft-start sequencer for PAIRS powered link pairs.
//            One FSM scans the pairs round-robin; at most one pair detects
//            or ramps at a time. Powered pairs are supervised for
//            over-current (fault) and disconnect (silent power-off).
// Options  : LINK_POWER_AUTO_RETRY_EN - when defined, each faulted pair
//            clears its fault after FAULT_RETRY_CYCLES and becomes eligible
//            again; when undefined, faults latch until Reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_power_sequencer #(
  parameter int PAIRS              = 2,
  parameter int DETECT_CYCLES      = 16,
  parameter int SOFTSTART_CYCLES   = 64,
  parameter int FAULT_RETRY_CYCLES = 256
) (
  input  logic             Clock100Mhz,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [PAIRS-1:0] PairPresent,
  input  logic [PAIRS-1:0] PairOverCurrent,
  output logic [PAIRS-1:0] PairPowerOn,
  output logic [PAIRS-1:0] PairSoftStart,
  output logic [PAIRS-1:0] PairFault,
  output logic             Busy,
  output logic             PowerGood
);

  localparam int PW   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int CMAX = (DETECT_CYCLES > SOFTSTART_CYCLES) ? DETECT_CYCLES : SOFTSTART_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0] PTR_LAST   = PW'(PAIRS - 1);
  localparam logic [CW-1:0] DETECT_END = CW'(DETECT_CYCLES - 1);
  localparam logic [CW-1:0] RAMP_END   = CW'(SOFTSTART_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DETECT = 2'd1,
    ST_RAMP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PAIRS-1:0]  pon_q, pon_d;
  logic [PAIRS-1:0]  ss_q, ss_d;
  logic [PAIRS-1:0]  fault_q, fault_d;

`ifdef LINK_POWER_AUTO_RETRY_EN
  localparam int            RW         = $clog2(FAULT_RETRY_CYCLES + 1);
  localparam logic [RW-1:0] RETRY_LOAD = RW'(FAULT_RETRY_CYCLES);
  logic [RW-1:0] retry_q [PAIRS];
  logic [RW-1:0] retry_d [PAIRS];
`endif

  // Round-robin pointer step, wrapping the last pair back to pair 0.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Next-state logic: pair supervision, scan/detect/ramp sequencing,
  // global Enable override and (optionally) fault retry timers.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pon_d   = pon_q;
    ss_d    = ss_q;
    fault_d = fault_q;

`ifdef LINK_POWER_AUTO_RETRY_EN
    // A fault releases the cycle after its hold-off timer has expired.
    for (int i = 0; i < PAIRS; i++) begin
      if (fault_q[i] && (retry_q[i] == '0)) begin
        fault_d[i] = 1'b0;
      end
    end
`endif

    // Supervise powered pairs; over-current wins over a simultaneous disconnect.
    for (int i = 0; i < PAIRS; i++) begin
      if (pon_q[i]) begin
        if (PairOverCurrent[i]) begin
          pon_d[i]   = 1'b0;
          fault_d[i] = 1'b1;
        end else if (!PairPresent[i]) begin
          pon_d[i] = 1'b0;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (Enable && !pon_q[ptr_q] && !fault_q[ptr_q] && PairPresent[ptr_q]) begin
          state_d = ST_DETECT;
          cnt_d   = '0;
        end else begin
          ptr_d = ptr_next(ptr_q);
        end
      end

      ST_DETECT: begin
        if (!PairPresent[ptr_q]) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_next(ptr_q);
          cnt_d   = '0;
        end else if (cnt_q == DETECT_END) begin
          state_d     = ST_RAMP;
          cnt_d       = '0;
          ss_d[ptr_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RAMP: begin
        if (PairOverCurrent[ptr_q]) begin
          ss_d[ptr_q]    = 1'b0;
          fault_d[ptr_q] = 1'b1;
          state_d        = ST_IDLE;
          ptr_d          = ptr_next(ptr_q);
          cnt_d          = '0;
        end else if (cnt_q == RAMP_END) begin
          ss_d[ptr_q]  = 1'b0;
          pon_d[ptr_q] = 1'b1;
          state_d      = ST_IDLE;
          ptr_d        = ptr_next(ptr_q);
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Losing global permission drops all power at once; faults keep running.
    if (!Enable) begin
      pon_d   = '0;
      ss_d    = '0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

`ifdef LINK_POWER_AUTO_RETRY_EN
    // Timers load when a fault is raised and count down while it is held.
    for (int i = 0; i < PAIRS; i++) begin
      retry_d[i] = retry_q[i];
      if (fault_d[i] && !fault_q[i]) begin
        retry_d[i] = RETRY_LOAD;
      end else if (fault_q[i] && (retry_q[i] != '0)) begin
        retry_d[i] = retry_q[i] - RW'(1);
      end
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pon_q   <= '0;
      ss_q    <= '0;
      fault_q <= '0;
`ifdef LINK_POWER_AUTO_RETRY_EN
      for (int i = 0; i < PAIRS; i++) begin
        retry_q[i] <= '0;
      end
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pon_q   <= pon_d;
      ss_q    <= ss_d;
      fault_q <= fault_d;
`ifdef LINK_POWER_AUTO_RETRY_EN
      for (int i = 0; i < PAIRS; i++) begin
        retry_q[i] <= retry_d[i];
      end
`endif
    end
  end

  assign PairPowerOn   = pon_q;
  assign PairSoftStart = ss_q;
  assign PairFault     = fault_q;
  assign Busy          = (state_q != ST_IDLE);
  assign PowerGood     = Enable && (|pon_q) && !(|fault_q);

endmodule

`default_nettype wire

// File: tb/tb_link_power_sequencer.sv
// ============================================================================
// Module   : tb_link_power_sequencer
// Purpose  : Directed self-checking bench for link_power_sequencer with
//            PAIRS=2, DETECT_CYCLES=4, SOFTSTART_CYCLES=8,
//            FAULT_RETRY_CYCLES=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_link_power_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] present;
  logic [1:0] oc;
  logic [1:0] pon;
  logic [1:0] ss;
  logic [1:0] fault;
  logic       busy;
  logic       pgood;

  int n_tests = 0;
  int n_fail  = 0;

  link_power_sequencer #(
    .PAIRS             (2),
    .DETECT_CYCLES     (4),
    .SOFTSTART_CYCLES  (8),
    .FAULT_RETRY_CYCLES(16)
  ) dut (
    .Clock100Mhz    (clk),
    .Reset          (rst),
    .Enable         (en),
    .PairPresent    (present),
    .PairOverCurrent(oc),
    .PairPowerOn    (pon),
    .PairSoftStart  (ss),
    .PairFault      (fault),
    .Busy           (busy),
    .PowerGood      (pgood)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling/driving happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    present = 2'b00;
    oc      = 2'b00;
    step();
    step();
  endtask

  // Wait (bounded) until all bits of mask are powered.
  task automatic wait_pon(input string tag, input logic [1:0] mask, input int budget);
    int k;
    k = 0;
    while (((pon & mask) != mask) && (k < budget)) begin
      step();
      k++;
    end
    check(tag, 32'(pon & mask), 32'(mask));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ss_cnt;
    int overlap;
    int order_bad;
    int ss_seen;
    int k;
    bit done;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_pon",   32'(pon),   32'h0);
    check("rst_ss",    32'(ss),    32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_pg",    32'(pgood), 32'h0);

    // ---------------- single pair power-up ----------------
    rst = 1'b0; en = 1'b1; present = 2'b01;
    step();
    check("t1_busy_rise", 32'(busy), 32'h1);
    ss_cnt = 0; ss_seen = 0; done = 1'b0;
    for (k = 0; k < 100 && !done; k++) begin
      step();
      if (ss[0]) ss_cnt++;
      if (ss[1]) ss_seen++;
      if (pon[0]) done = 1'b1;
    end
    check("t1_pon0",      32'(pon),    32'h1);
    check("t1_ss_fall",   32'(ss),     32'h0);
    check("t1_ss_len",    32'(ss_cnt), 32'd8);
    check("t1_no_ss1",    32'(ss_seen), 32'd0);
    check("t1_pgood",     32'(pgood),  32'h1);
    check("t1_busy_fall", 32'(busy),   32'h0);

    // ---------------- two pairs, sequential ramps ----------------
    do_reset();
    rst = 1'b0; en = 1'b1; present = 2'b11;
    overlap = 0; order_bad = 0;
    for (k = 0; k < 200 && pon != 2'b11; k++) begin
      step();
      if (ss == 2'b11) overlap++;
      if ((ss[1] || pon[1]) && !pon[0]) order_bad++;
    end
    check("t2_pon_both",  32'(pon),       32'h3);
    check("t2_overlap",   32'(overlap),   32'd0);
    check("t2_order",     32'(order_bad), 32'd0);
    check("t2_ss_idle",   32'(ss),        32'h0);

    // ---------------- over-current on powered pair 1 ----------------
    oc = 2'b10;
    step();
    oc = 2'b00;
    check("t3_pon",   32'(pon),   32'h1);
    check("t3_fault", 32'(fault), 32'h2);
    check("t3_pg",    32'(pgood), 32'h0);
`ifdef LINK_POWER_AUTO_RETRY_EN
    for (k = 0; k < 16; k++) step();
    check("t3_fault_hold", 32'(fault), 32'h2);
    step();
    check("t3_fault_clr",  32'(fault), 32'h0);
    wait_pon("t3_reramp", 2'b11, 100);
    check("t3_pg_back", 32'(pgood), 32'h1);
`else
    for (k = 0; k < 40; k++) step();
    check("t3_fault_latch", 32'(fault), 32'h2);
    check("t3_pon_hold",    32'(pon),   32'h1);
`endif

    // ---------------- detect abort ----------------
    do_reset();
    rst = 1'b0; en = 1'b1; present = 2'b01;
    step();
    check("t4_det_busy1", 32'(busy), 32'h1);
    step();
    check("t4_det_busy2", 32'(busy), 32'h1);
    present = 2'b00;
    step();
    check("t4_abort_busy", 32'(busy), 32'h0);
    oc = 2'b11;  // over-current on unpowered, non-ramping pairs is ignored
    step();
    oc = 2'b00;
    ss_seen = 0;
    for (k = 0; k < 5; k++) begin
      step();
      if (ss != 2'b00) ss_seen++;
    end
    check("t4_no_ss",      32'(ss_seen), 32'd0);
    check("t4_oc_ignored", 32'(fault),   32'h0);
    present = 2'b01;
    wait_pon("t4_redetect", 2'b01, 100);
    // Disconnect of a powered pair: power off, no fault.
    present = 2'b00;
    step();
    check("t4_disc_pon",   32'(pon),   32'h0);
    check("t4_disc_fault", 32'(fault), 32'h0);

    // ---------------- Enable drop mid-ramp ----------------
    do_reset();
    rst = 1'b0; en = 1'b1; present = 2'b01;
    for (k = 0; k < 5; k++) step();
    check("t5_ramp_start", 32'(ss), 32'h1);
    step();
    step();
    en = 1'b0;
    step();
    check("t5_en_ss",   32'(ss),   32'h0);
    check("t5_en_pon",  32'(pon),  32'h0);
    check("t5_en_busy", 32'(busy), 32'h0);

    // Over-current together with disconnect counts as over-current.
    do_reset();
    rst = 1'b0; en = 1'b1; present = 2'b01;
    wait_pon("t5_pon0", 2'b01, 100);
    oc = 2'b01; present = 2'b00;
    step();
    oc = 2'b00;
    check("t5_oc_disc_fault", 32'(fault), 32'h1);
    check("t5_oc_disc_pon",   32'(pon),   32'h0);

    // ---------------- reset mid-ramp ----------------
    do_reset();
    rst = 1'b0; en = 1'b1; present = 2'b01;
    for (k = 0; k < 7; k++) step();
    check("t6_in_ramp", 32'(ss), 32'h1);
    rst = 1'b1;
    step();
    check("t6_rst_ss",   32'(ss),   32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_pon",  32'(pon),  32'h0);

    // ---------------- reset mid-retry ----------------
    rst = 1'b0;
    wait_pon("t6_pon0", 2'b01, 100);
    oc = 2'b01;
    step();
    oc = 2'b00;
    check("t6_fault_set", 32'(fault), 32'h1);
    step(); step(); step();
    rst = 1'b1;
    step();
    check("t6_rst_fault", 32'(fault), 32'h0);
    check("t6_rst_pg",    32'(pgood), 32'h0);
    rst = 1'b0;
    wait_pon("t6_resume", 2'b01, 100);
    check("t6_resume_pg", 32'(pgood), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/link_power_sequencer.md
LINK_POWER_SEQUENCER -- requirements
Module: link_power_sequencer

Interface
REQ-001 SHALL have parameter PAIRS, default 2, number of powered link pairs (range 1..8).
REQ-002 SHALL have parameter DETECT_CYCLES, default 16, consecutive present cycles required before power-up.
REQ-003 SHALL have parameter SOFTSTART_CYCLES, default 64, ramp duration per pair.
REQ-004 SHALL have parameter FAULT_RETRY_CYCLES, default 256, fault hold-off before re-detection.
REQ-005 SHALL have port Clock100Mhz  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Enable  input  1  global power permission.
REQ-008 SHALL have port PairPresent  input  PAIRS  per-pair valid load signature.
REQ-009 SHALL have port PairOverCurrent  input  PAIRS  per-pair over-current flag.
REQ-010 SHALL have port PairPowerOn  output  PAIRS  per-pair steady power enable.
REQ-011 SHALL have port PairSoftStart  output  PAIRS  per-pair ramp enable.
REQ-012 SHALL have port PairFault  output  PAIRS  per-pair fault status.
REQ-013 SHALL have port Busy  output  1  sequencer not in IDLE.
REQ-014 SHALL have port PowerGood  output  1  Enable high, at least one PairPowerOn bit set, and no PairFault bit set.

Function
REQ-015 SHALL contain one shared FSM with states IDLE, DETECT, RAMP and a scan pointer 0..PAIRS-1, so at most one pair detects or ramps at a time.
REQ-016 In IDLE, a pair is eligible when Enable=1, PairPowerOn=0, PairFault=0 and PairPresent=1 at the pointer. An eligible pair moves the FSM to DETECT next cycle; otherwise the pointer advances one step per cycle, wrapping PAIRS-1 to 0.
REQ-017 DETECT SHALL count cycles in which PairPresent[ptr]=1. After DETECT_CYCLES such cycles it moves to RAMP; any cycle with PairPresent[ptr]=0 returns it to IDLE with the pointer advanced.
REQ-018 RAMP SHALL hold PairSoftStart[ptr]=1 for exactly SOFTSTART_CYCLES cycles. On the following cycle PairSoftStart[ptr]=0, PairPowerOn[ptr]=1, the FSM enters IDLE and the pointer advances.
REQ-019 PairOverCurrent[ptr]=1 during RAMP SHALL, next cycle, clear PairSoftStart[ptr], set PairFault[ptr], enter IDLE and advance the pointer.
REQ-020 PairOverCurrent[i]=1 on a pair with PairPowerOn[i]=1 SHALL, next cycle, clear PairPowerOn[i] and set PairFault[i].
REQ-021 PairPresent[i]=0 on a pair with PairPowerOn[i]=1 SHALL, next cycle, clear PairPowerOn[i] with no fault.
REQ-022 Over-current and disconnect in the same cycle SHALL be treated as over-current: fault set.
REQ-023 Enable=0 SHALL, next cycle, clear all PairPowerOn and PairSoftStart bits and force IDLE. Fault state and retry timers SHALL continue to run.
REQ-024 Over-current SHALL be ignored on pairs that are neither ramping nor powered.
REQ-025 Each pair SHALL own a retry counter wide enough for FAULT_RETRY_CYCLES. It loads on fault set and decrements each cycle while the fault is held; fault clear behaviour is defined in Configuration.
REQ-026 Busy SHALL be 1 exactly when the FSM is in DETECT or RAMP.

Reset
REQ-027 Reset=1 SHALL, on the next edge: set FSM=IDLE, pointer=0, all counters=0, PairPowerOn=0, PairSoftStart=0, PairFault=0, Busy=0, PowerGood=0.
REQ-028 Reset SHALL override all other inputs in the same cycle, including mid-ramp and mid-retry.

Configuration
REQ-029 With macro LINK_POWER_AUTO_RETRY_EN defined, PairFault[i] SHALL clear on the cycle after its retry counter reaches 0, making the pair eligible again.
REQ-030 Without LINK_POWER_AUTO_RETRY_EN, PairFault[i] SHALL latch until Reset, and the retry counters SHALL be omitted.

Verification (PAIRS=2, DETECT_CYCLES=4, SOFTSTART_CYCLES=8, FAULT_RETRY_CYCLES=16)
REQ-031 Enable=1, PairPresent=2'b01 from reset release -> Busy rises, PairSoftStart[0] is high exactly 8 cycles, PairPowerOn[0] rises the cycle PairSoftStart[0] falls, PowerGood=1.
REQ-032 Both pairs present -> ramps are strictly sequential, never overlapping: pair 0 powers first, then pair 1; final PairPowerOn=2'b11.
REQ-033 Pulse PairOverCurrent[1] for 1 cycle with PairPowerOn=2'b11 -> next cycle PairPowerOn=2'b01, PairFault=2'b10, PowerGood=0. With the macro defined, the fault clears after 16 cycles and pair 1 re-ramps; without it, the fault persists.
REQ-034 PairPresent[0] dropped on cycle 2 of DETECT -> no PairSoftStart, FSM returns to IDLE, pair 0 is re-detected when present again.
REQ-035 Enable=0 at RAMP cycle 3 -> next cycle PairSoftStart=0, PairPowerOn=0, Busy=0. Same-cycle PairOverCurrent[0] and PairPresent[0]=0 on a powered pair -> PairFault[0]=1.
REQ-036 Reset asserted mid-RAMP and mid-retry -> all outputs 0 on the next edge; normal sequencing resumes after release.
